// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundle of the data-memory arbiter's bus signals.
//   CPU side : cpu_wea, cpu_rea, cpu_addr, cpu_din, cpu_en -> arbiter; cpu_dout, mem_hold <- arbiter
//   DMA side : dma_req, dma_we, dma_addr, dma_din, dma_en -> arbiter; dma_gnt, dma_rvalid, dma_dout <- arbiter
//   BRAM side: mem_wea, mem_rea, mem_en, mem_addr, mem_din <- arbiter; mem_dout -> arbiter
// Modport slave is the arbiter's view; modport master is the surrounding
// system (pipeline, DMA engine and BRAM) driving it.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_wea;
  logic              cpu_rea;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_din;
  logic [3:0]        cpu_en;
  logic [DATA_W-1:0] cpu_dout;
  logic              mem_hold;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_din;
  logic [3:0]        dma_en;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_dout;

  logic              mem_wea;
  logic              mem_rea;
  logic [3:0]        mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport slave (
    input  cpu_wea, cpu_rea, cpu_addr, cpu_din, cpu_en,
    output cpu_dout, mem_hold,
    input  dma_req, dma_we, dma_addr, dma_din, dma_en,
    output dma_gnt, dma_rvalid, dma_dout,
    output mem_wea, mem_rea, mem_en, mem_addr, mem_din,
    input  mem_dout
  );

  modport master (
    output cpu_wea, cpu_rea, cpu_addr, cpu_din, cpu_en,
    input  cpu_dout, mem_hold,
    output dma_req, dma_we, dma_addr, dma_din, dma_en,
    input  dma_gnt, dma_rvalid, dma_dout,
    input  mem_wea, mem_rea, mem_en, mem_addr, mem_din,
    output mem_dout
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port synchronous data BRAM between the
// CPU MEM stage and a DMA requester, one access per cycle.
//   clk : system clock
//   Rst : asynchronous active-high reset
//   bus : dmem_arbiter_if.slave (CPU request/load data + mem_hold,
//         DMA request/grant/read return, BRAM port)
// The CPU normally has priority; a DMA request left waiting for STARVE_LIM
// cycles wins one forced cycle, during which mem_hold stalls the pipeline.
// BRAM read data returns one cycle after the access; the CPU's last load
// result is kept in cpu_rdata_q so DMA traffic never disturbs write-back.
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 8
) (
  input  logic          clk,
  input  logic          Rst,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  localparam logic [7:0] LIM = 8'(STARVE_LIM);

  owner_e            owner;
  owner_e            rd_owner_d, rd_owner_q;
  logic [7:0]        starve_cnt_d, starve_cnt_q;
  logic [DATA_W-1:0] cpu_rdata_d, cpu_rdata_q;

  logic              cpu_req;
  logic              force_dma;
  logic              gnt;
  logic              mux_wea;
  logic              mux_rea;
  logic [3:0]        mux_en;
  logic [ADDR_W-1:0] mux_addr;
  logic [DATA_W-1:0] mux_din;

  // Owner selection; reset forces the port idle so nothing reaches the BRAM.
  always_comb begin
    cpu_req   = bus.cpu_wea | bus.cpu_rea;
    force_dma = (starve_cnt_q == LIM);
    owner     = OWN_NONE;
    if (!Rst) begin
      if (force_dma && bus.dma_req) owner = OWN_DMA;
      else if (cpu_req)             owner = OWN_CPU;
      else if (bus.dma_req)         owner = OWN_DMA;
    end
  end

  // Port mux. A CPU access with both wea and rea set is a store, so rea is
  // masked there. When idle, address/data still follow the CPU.
  always_comb begin
    mux_wea  = 1'b0;
    mux_rea  = 1'b0;
    mux_en   = 4'b0000;
    mux_addr = bus.cpu_addr;
    mux_din  = bus.cpu_din;
    case (owner)
      OWN_CPU: begin
        mux_wea = bus.cpu_wea;
        mux_rea = bus.cpu_rea & ~bus.cpu_wea;
        mux_en  = bus.cpu_en;
      end
      OWN_DMA: begin
        mux_wea  = bus.dma_we;
        mux_rea  = ~bus.dma_we;
        mux_en   = bus.dma_en;
        mux_addr = bus.dma_addr;
        mux_din  = bus.dma_din;
      end
      default: ;
    endcase
  end

  // Next-state: starvation counter, read-return owner, held CPU load data.
  always_comb begin
    gnt = (owner == OWN_DMA);

    starve_cnt_d = starve_cnt_q;
    if (gnt || !bus.dma_req)  starve_cnt_d = 8'd0;
    else if (!force_dma)      starve_cnt_d = starve_cnt_q + 8'd1;

    rd_owner_d = OWN_NONE;
    if (owner == OWN_CPU && bus.cpu_rea && !bus.cpu_wea) rd_owner_d = OWN_CPU;
    else if (owner == OWN_DMA && !bus.dma_we)            rd_owner_d = OWN_DMA;

    cpu_rdata_d = (rd_owner_q == OWN_CPU) ? bus.mem_dout : cpu_rdata_q;
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      starve_cnt_q <= 8'd0;
      rd_owner_q   <= OWN_NONE;
      cpu_rdata_q  <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rd_owner_q   <= rd_owner_d;
      cpu_rdata_q  <= cpu_rdata_d;
    end
  end

  assign bus.mem_wea    = mux_wea;
  assign bus.mem_rea    = mux_rea;
  assign bus.mem_en     = mux_en;
  assign bus.mem_addr   = mux_addr;
  assign bus.mem_din    = mux_din;
  assign bus.dma_gnt    = gnt;
  assign bus.mem_hold   = cpu_req & gnt;
  assign bus.dma_rvalid = (rd_owner_q == OWN_DMA);
  assign bus.dma_dout   = bus.mem_dout;
  // Load data is live from the BRAM the cycle after a CPU read, otherwise held.
  assign bus.cpu_dout   = (rd_owner_q == OWN_CPU) ? bus.mem_dout : cpu_rdata_q;

endmodule
